// File: rtl/csr_trap_if.sv
// Bundles the trap, mret, CSR access, interrupt-line and redirect signals of
// csr_trap_unit. The master side is the pipeline or testbench, and the slave
// side is the CSR/trap unit.
interface csr_trap_if;
  logic        trap_flush;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;
  logic        mret;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        msip;
  logic        mtip;
  logic        meip;
  logic [31:0] mstatus_o;
  logic [31:0] mie_o;
  logic [31:0] mip_o;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output trap_flush, trap_pc, trap_cause, trap_tval, mret,
    output csr_en, csr_op, csr_addr, csr_wdata, msip, mtip, meip,
    input  csr_rdata, csr_illegal, mstatus_o, mie_o, mip_o,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  trap_flush, trap_pc, trap_cause, trap_tval, mret,
    input  csr_en, csr_op, csr_addr, csr_wdata, msip, mtip, meip,
    output csr_rdata, csr_illegal, mstatus_o, mie_o, mip_o,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap-commit controller.
// It commits trap records, executes CSRRW/RS/RC, handles mret, and issues a
// one-cycle PC redirect to the trap vector or to mepc.
module csr_trap_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  csr_trap_if.slave   bus
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t      state, state_next;

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mie_reg;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [63:0] mcycle;
  logic [31:0] redirect_pc_q;

  logic [31:0] mstatus_val;
  logic [31:0] mip_val;
  logic [31:0] rdata;
  logic        addr_hit;
  logic        addr_ro;
  logic        write_try;
  logic        illegal;
  logic        do_write;
  logic [31:0] wval;
  logic [3:0]  code;
  logic        is_int;
  logic [31:0] vec_base;
  logic [31:0] trap_target;
  logic        unused_cause;

  assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign mip_val     = {20'b0, bus.meip, 3'b0, bus.mtip, 3'b0, bus.msip, 3'b0};

  // The upper cause bits carry no information for this hart.
  assign unused_cause = ^bus.trap_cause[31:4];

  assign code        = bus.trap_cause[3:0];
  assign is_int      = (code == 4'd3) || (code == 4'd7) || (code == 4'd11);
  assign vec_base    = {mtvec[31:2], 2'b00};
  assign trap_target = (mtvec[0] && is_int) ? vec_base + {26'b0, code, 2'b00} : vec_base;

  // CSR read mux, address decode, and read-only classification.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave a latch behind.
    rdata    = '0;
    addr_hit = 1'b1;
    addr_ro  = 1'b0;
    unique case (bus.csr_addr)
      ADDR_MSTATUS:  rdata = mstatus_val;
      ADDR_MISA:     begin rdata = MISA_VALUE; addr_ro = 1'b1; end
      ADDR_MIE:      rdata = mie_reg;
      ADDR_MTVEC:    rdata = mtvec;
      ADDR_MSCRATCH: rdata = mscratch;
      ADDR_MEPC:     rdata = mepc;
      ADDR_MCAUSE:   rdata = mcause;
      ADDR_MTVAL:    rdata = mtval;
      ADDR_MIP:      begin rdata = mip_val; addr_ro = 1'b1; end
      ADDR_MCYCLE:   rdata = mcycle[31:0];
      ADDR_MCYCLEH:  rdata = mcycle[63:32];
      ADDR_MHARTID:  begin rdata = HART_ID; addr_ro = 1'b1; end
      default:       addr_hit = 1'b0;
    endcase
  end

  // Compute the write value and decide whether this cycle's CSR write survives.
  always_comb begin
    wval = '0;
    unique case (bus.csr_op)
      OP_RW:   wval = bus.csr_wdata;
      OP_RS:   wval = rdata | bus.csr_wdata;
      OP_RC:   wval = rdata & ~bus.csr_wdata;
      default: wval = rdata;
    endcase
    // RS/RC with a zero operand count as reads, so they are legal on read-only CSRs.
    write_try = bus.csr_en &&
                ((bus.csr_op == OP_RW) ||
                 ((bus.csr_op != OP_READ) && (bus.csr_wdata != '0)));
    illegal   = bus.csr_en && (!addr_hit || (addr_ro && write_try));
    do_write  = write_try && !illegal && !bus.trap_flush && !bus.mret;
  end

  // Redirect FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop update from the pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Redirect FSM next state: every trap or mret (re)enters REDIRECT for one cycle.
  always_comb begin
    state_next = IDLE;
    if (bus.trap_flush || bus.mret) state_next = REDIRECT;
  end

  // Architectural CSR state, trap/mret commit, and the free-running cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie   <= 1'b0;
      mstatus_mpie  <= 1'b0;
      mie_reg       <= '0;
      mtvec         <= MTVEC_RESET;
      mscratch      <= '0;
      mepc          <= '0;
      mcause        <= '0;
      mtval         <= '0;
      mcycle        <= '0;
      redirect_pc_q <= '0;
    end else begin
      if (do_write && (bus.csr_addr == ADDR_MCYCLE))
        mcycle <= {mcycle[63:32], wval};
      else if (do_write && (bus.csr_addr == ADDR_MCYCLEH))
        mcycle <= {wval, mcycle[31:0]};
      else
        mcycle <= mcycle + 64'd1;

      if (bus.trap_flush) begin
        mepc          <= bus.trap_pc & ~32'd3;
        mtval         <= bus.trap_tval;
        mcause        <= {is_int, 27'b0, code};
        mstatus_mpie  <= mstatus_mie;
        mstatus_mie   <= 1'b0;
        redirect_pc_q <= trap_target;
      end else if (bus.mret) begin
        mstatus_mie   <= mstatus_mpie;
        mstatus_mpie  <= 1'b1;
        redirect_pc_q <= mepc;
      end else if (do_write) begin
        unique case (bus.csr_addr)
          ADDR_MSTATUS: begin
            mstatus_mie  <= wval[3];
            mstatus_mpie <= wval[7];
          end
          ADDR_MIE:      mie_reg  <= wval & MIE_MASK;
          ADDR_MTVEC:    mtvec    <= wval & ~32'd2;
          ADDR_MSCRATCH: mscratch <= wval;
          ADDR_MEPC:     mepc     <= wval & ~32'd3;
          ADDR_MCAUSE:   mcause   <= wval;
          ADDR_MTVAL:    mtval    <= wval;
          default:       ;
        endcase
      end
    end
  end

  assign bus.csr_rdata      = rdata;
  assign bus.csr_illegal    = illegal;
  assign bus.mstatus_o      = mstatus_val;
  assign bus.mie_o          = mie_reg;
  assign bus.mip_o          = mip_val;
  assign bus.redirect_valid = (state == REDIRECT);
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed testbench for csr_trap_unit. It covers reset values, trap commit,
// vectored and direct redirects, mret, same-cycle priority, field masks,
// mcycle carry, read-only and illegal accesses, and reset during a redirect.
module tb_csr_trap_unit;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  csr_trap_if bus ();

  csr_trap_unit #(
    .MTVEC_RESET(32'h0000_0000),
    .MISA_VALUE (32'h4000_0100),
    .HART_ID    (32'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge. Outputs are read before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    bus.csr_en   = 1'b1;
    bus.csr_op   = 2'b00;
    bus.csr_addr = addr;
    #1;
    check(tag, bus.csr_rdata, exp);
    bus.csr_en = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data);
    bus.csr_en    = 1'b1;
    bus.csr_op    = op;
    bus.csr_addr  = addr;
    bus.csr_wdata = data;
    tick();
    bus.csr_en = 1'b0;
    bus.csr_op = 2'b00;
  endtask

  task automatic set_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval);
    bus.trap_flush = 1'b1;
    bus.trap_cause = cause;
    bus.trap_pc    = pc;
    bus.trap_tval  = tval;
  endtask

  initial begin
    rst            = 1'b1;
    bus.trap_flush = 1'b0;
    bus.trap_pc    = '0;
    bus.trap_cause = '0;
    bus.trap_tval  = '0;
    bus.mret       = 1'b0;
    bus.csr_en     = 1'b0;
    bus.csr_op     = 2'b00;
    bus.csr_addr   = '0;
    bus.csr_wdata  = '0;
    bus.msip       = 1'b0;
    bus.mtip       = 1'b0;
    bus.meip       = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_redirect_valid", {31'b0, bus.redirect_valid}, 32'd0);
    check("rst_redirect_pc", bus.redirect_pc, 32'd0);
    check("rst_mie_o", bus.mie_o, 32'd0);
    rd(12'h300, 32'h0000_1800, "rst_mstatus");
    rd(12'h305, 32'h0000_0000, "rst_mtvec");
    bus.csr_en   = 1'b1;
    bus.csr_addr = 12'hB00;
    #1;
    check("rst_mcycle_small", {31'b0, (bus.csr_rdata < 32'd64)}, 32'd1);
    bus.csr_en = 1'b0;
    tick();

    // Direct-mode trap with an interrupt cause
    wr(2'b01, 12'h300, 32'h0000_0008);
    check("mstatus_mie_set", bus.mstatus_o, 32'h0000_1808);
    wr(2'b01, 12'h305, 32'h0000_0100);
    set_trap(32'd11, 32'h0000_2002, 32'h0000_DEAD);
    tick();
    bus.trap_flush = 1'b0;
    check("trap_redirect_valid", {31'b0, bus.redirect_valid}, 32'd1);
    check("trap_redirect_pc", bus.redirect_pc, 32'h0000_0100);
    check("trap_mstatus", bus.mstatus_o, 32'h0000_1880);
    tick();
    check("trap_redirect_done", {31'b0, bus.redirect_valid}, 32'd0);
    rd(12'h341, 32'h0000_2000, "trap_mepc");
    rd(12'h342, 32'h8000_000B, "trap_mcause");
    rd(12'h343, 32'h0000_DEAD, "trap_mtval");

    // mret restores MIE from MPIE and returns to mepc
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    check("mret_redirect_valid", {31'b0, bus.redirect_valid}, 32'd1);
    check("mret_redirect_pc", bus.redirect_pc, 32'h0000_2000);
    check("mret_mstatus", bus.mstatus_o, 32'h0000_1888);
    tick();
    check("mret_redirect_done", {31'b0, bus.redirect_valid}, 32'd0);

    // Vectored mode: back-to-back traps re-enter REDIRECT with a new target
    wr(2'b01, 12'h305, 32'h0000_0101);
    set_trap(32'd7, 32'h0000_4000, 32'h0);
    tick();
    check("vec_int_redirect_pc", bus.redirect_pc, 32'h0000_011C);
    set_trap(32'd2, 32'h0000_4000, 32'h0);
    tick();
    bus.trap_flush = 1'b0;
    check("vec_exc_redirect_valid", {31'b0, bus.redirect_valid}, 32'd1);
    check("vec_exc_redirect_pc", bus.redirect_pc, 32'h0000_0100);
    tick();
    check("vec_redirect_done", {31'b0, bus.redirect_valid}, 32'd0);
    rd(12'h342, 32'h0000_0002, "vec_exc_mcause");
    check("vec_mstatus", bus.mstatus_o, 32'h0000_1800);

    // Priority: trap_flush drops the same-cycle mret and CSR write
    wr(2'b01, 12'h340, 32'h0000_000A);
    set_trap(32'd2, 32'h0000_3000, 32'h0);
    bus.mret      = 1'b1;
    bus.csr_en    = 1'b1;
    bus.csr_op    = 2'b01;
    bus.csr_addr  = 12'h340;
    bus.csr_wdata = 32'd5;
    tick();
    bus.trap_flush = 1'b0;
    bus.mret       = 1'b0;
    bus.csr_en     = 1'b0;
    check("prio_redirect_pc", bus.redirect_pc, 32'h0000_0100);
    check("prio_mstatus", bus.mstatus_o, 32'h0000_1800);
    tick();
    rd(12'h340, 32'h0000_000A, "prio_mscratch");
    rd(12'h341, 32'h0000_3000, "prio_mepc");

    // Field masks and set/clear operations
    wr(2'b01, 12'h304, 32'hFFFF_FFFF);
    rd(12'h304, 32'h0000_0888, "mie_mask");
    wr(2'b11, 12'h304, 32'h0000_0008);
    rd(12'h304, 32'h0000_0880, "mie_clear");
    wr(2'b10, 12'h300, 32'hFFFF_FFFF);
    rd(12'h300, 32'h0000_1888, "mstatus_set");
    wr(2'b01, 12'h341, 32'h0000_1237);
    rd(12'h341, 32'h0000_1234, "mepc_mask");
    wr(2'b01, 12'h305, 32'h0000_0103);
    rd(12'h305, 32'h0000_0101, "mtvec_mask");

    // mcycle carry from the low half into the high half
    wr(2'b01, 12'hB80, 32'h0000_0000);
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle_loaded");
    rd(12'hB00, 32'h0000_0000, "mcycle_wrap_lo");
    rd(12'hB80, 32'h0000_0001, "mcycle_wrap_hi");

    // mip is live and read-only; illegal accesses
    bus.msip = 1'b1;
    bus.meip = 1'b1;
    #1;
    check("mip_o_live", bus.mip_o, 32'h0000_0808);
    bus.csr_en    = 1'b1;
    bus.csr_op    = 2'b10;
    bus.csr_addr  = 12'h344;
    bus.csr_wdata = 32'h0000_0080;
    #1;
    check("mip_write_illegal", {31'b0, bus.csr_illegal}, 32'd1);
    tick();
    bus.csr_en = 1'b0;
    rd(12'h344, 32'h0000_0808, "mip_unchanged");
    bus.csr_en   = 1'b1;
    bus.csr_op   = 2'b00;
    bus.csr_addr = 12'h7C0;
    #1;
    check("unimpl_illegal", {31'b0, bus.csr_illegal}, 32'd1);
    check("unimpl_rdata", bus.csr_rdata, 32'd0);
    bus.csr_addr = 12'h340;
    #1;
    check("legal_not_illegal", {31'b0, bus.csr_illegal}, 32'd0);
    bus.csr_en = 1'b0;
    tick();
    rd(12'h301, 32'h4000_0100, "misa");
    rd(12'hF14, 32'h0000_0000, "mhartid");

    // Reset during a redirect discards it
    set_trap(32'd2, 32'h0000_5000, 32'h0);
    tick();
    bus.trap_flush = 1'b0;
    check("pre_rst_redirect_valid", {31'b0, bus.redirect_valid}, 32'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_redirect_valid", {31'b0, bus.redirect_valid}, 32'd0);
    check("rst_mid_redirect_pc", bus.redirect_pc, 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
